port_pkt_top: RTL
=================

// Module: port_pkt_top
// PURPOSE
// - Next-generation switch output port: packet-aware admission in front of a parametrised FIFO.
// - Watches the shared switch input bus and accepts packets addressed to port_addr, plus broadcast when enabled.
// - Admits a packet only if the whole packet fits; otherwise drops it atomically.
// - Exposes occupancy and statistics counters; the egress side is a simple ready/read pop interface.
// PARAMETERS
// FIFO_SIZE  64  FIFO depth in words; power of 2, >= 2
// W_WIDTH    8   word width (data, address, length)
// CNT_WIDTH  16  width of statistics counters
// BCAST_EN   1   1: DA == all-ones is also accepted
// PORTS
// clk         in   1              clock, rising edge
// rst_n       in   1              asynchronous active-low reset
// sw_en       in   1              high for the whole duration of a packet on port_data
// port_data   in   W_WIDTH        packet stream: DA, LEN, then LEN payload words
// port_addr   in   W_WIDTH        this port's address; sampled at the DA cycle
// rd_out      out  1              FIFO not full
// port_rd     in   1              egress pop request
// port_out    out  W_WIDTH        egress data, registered
// port_rdy    out  1              FIFO not empty
// fill_level  out  clog2(FIFO_SIZE)+1  words currently stored
// drop_cnt    out  CNT_WIDTH      packets dropped for lack of space; saturating
// err_cnt     out  CNT_WIDTH      truncated packets; saturating
// BEHAVIOUR
// - Reset (async): FIFO empty; FSM in IDLE; port_out=0; port_rdy=0; rd_out=1; fill_level=0; drop_cnt=0; err_cnt=0.
// - Packet format:
//   - cycle 0 (sw_en rising): DA.
//   - cycle 1: LEN, 0..2^W_WIDTH-1.
//   - cycles 2..LEN+1: payload.
//   - sw_en must be low for >= 1 cycle between packets.
// - The FIFO stores LEN followed by the payload. DA is not stored.
// - FSM states:
//   - IDLE: sw_en=1 and (DA==port_addr or (BCAST_EN and DA=all-ones)) -> LEN. Other sw_en=1 -> SKIP.
//   - LEN: let free = FIFO_SIZE - fill_level, evaluated this cycle before any same-cycle pop.
//     - free >= LEN+1: write LEN, load payload counter with LEN. LEN==0 -> WAIT_END, else PAYLOAD.
//     - free < LEN+1: drop_cnt++ -> SKIP.
//     - sw_en=0 here: err_cnt++, no write -> IDLE.
//   - PAYLOAD: each cycle with sw_en=1, write port_data and decrement the counter. Counter reaches 0 -> WAIT_END.
//     - sw_en=0 before the counter reaches 0: err_cnt++ -> IDLE.
//     - Words already written stay in the FIFO; there is no rollback.
//   - WAIT_END / SKIP: no writes; sw_en=0 -> IDLE. Extra words beyond LEN are ignored.
// - Admission guarantees no overflow: pops only free space during a packet. Push while full is impossible by construction; assert in sim.
// - Egress: port_rd=1 with port_rdy=1 -> port_out takes the head word on the next clock edge (1-cycle latency), and the head advances.
//   - port_rd while empty is ignored; port_out holds its last value.
// - Same-cycle push and pop: fill_level unchanged; both take effect.
// - Read/write pointers are clog2(FIFO_SIZE) bits and wrap modulo FIFO_SIZE.
// - fill_level is an up/down counter, range 0..FIFO_SIZE.
// - rd_out = (fill_level != FIFO_SIZE); port_rdy = (fill_level != 0). Both are combinational from registered state.
// - Counters saturate at all-ones and never wrap.
// - port_addr changes mid-packet have no effect on the current packet.
// - rst_n asserted mid-packet: immediate clear. A partial packet on the bus after release is seen as non-IDLE traffic only after sw_en goes low, then high.
// TESTING
// 1. port_addr=0x05; send DA=05, LEN=3, 0xA1,A2,A3 -> fill_level=4; four pops return 03,A1,A2,A3; port_rdy=0 after the last pop.
// 2. Send DA=07 (port 05), LEN=2 -> no writes; fill_level, drop_cnt, err_cnt all unchanged.
// 3. FIFO_SIZE=8, preload 5 words; send DA=05, LEN=4 -> dropped, fill_level=5, drop_cnt=1. Then LEN=2 -> accepted, fill_level=8, rd_out=0.
// 4. BCAST_EN=1: DA=FF, LEN=0 -> one word 0x00 stored. Repeat with BCAST_EN=0 -> nothing stored.
// 5. DA=05, LEN=5, sw_en drops after 2 payload words -> err_cnt=1, fill_level=3. The next full packet is accepted normally.
// 6. Pop continuously during a 6-word ingest at fill_level=FIFO_SIZE-7 -> fill_level stays exact. Assert rst_n mid-payload -> all outputs at reset values.

Source files
------------

// File: rtl/port_pkt_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : port_pkt_top                                               |
// | Description : Switch output port. Watches the shared input bus, admits   |
// |               packets addressed to this port (and broadcast when         |
// |               enabled) only if the whole packet fits, and queues LEN +   |
// |               payload in a FIFO popped through a ready/read interface.   |
// | Ports       : clk, rst_n     - clock, async active-low reset             |
// |               sw_en,port_data- ingress bus (DA, LEN, LEN payload words)  |
// |               port_addr      - this port's address, used at the DA cycle |
// |               rd_out         - FIFO not full                             |
// |               port_rd        - egress pop request                        |
// |               port_out       - egress data, registered, 1-cycle latency  |
// |               port_rdy       - FIFO not empty                            |
// |               fill_level     - words stored                              |
// |               drop_cnt       - packets dropped for lack of space (sat.)  |
// |               err_cnt        - truncated packets (saturating)            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module port_pkt_top #(
  parameter int FIFO_SIZE = 64,
  parameter int W_WIDTH   = 8,
  parameter int CNT_WIDTH = 16,
  parameter bit BCAST_EN  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sw_en,
  input  logic [W_WIDTH-1:0]           port_data,
  input  logic [W_WIDTH-1:0]           port_addr,
  output logic                         rd_out,
  input  logic                         port_rd,
  output logic [W_WIDTH-1:0]           port_out,
  output logic                         port_rdy,
  output logic [$clog2(FIFO_SIZE):0]   fill_level,
  output logic [CNT_WIDTH-1:0]         drop_cnt,
  output logic [CNT_WIDTH-1:0]         err_cnt
);

  localparam int AW = $clog2(FIFO_SIZE);
  // Wide enough to hold both the free-space count and LEN+1 without overflow.
  localparam int CW = (((AW + 1) > W_WIDTH) ? (AW + 1) : W_WIDTH) + 1;
  localparam logic [AW:0] c_depth = (AW + 1)'(FIFO_SIZE);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_len     = 3'd1;
  localparam logic [2:0] c_st_payload = 3'd2;
  localparam logic [2:0] c_st_waitend = 3'd3;
  localparam logic [2:0] c_st_skip    = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [W_WIDTH-1:0]   cnt_q, cnt_d;
  logic                 sw_en_q;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          fill_q;
  logic [W_WIDTH-1:0]   port_out_q;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic [W_WIDTH-1:0]   mem_q [FIFO_SIZE];

  logic        w_push, w_pop, w_match, w_fits, w_start;
  logic        w_drop_inc, w_err_inc;
  logic [AW:0] w_free;

  // A DA cycle is recognised only on a rising sw_en. sw_en_q resets high so a
  // packet already in flight when reset releases is ignored until sw_en drops.
  assign w_start = sw_en && !sw_en_q;
  assign w_match = (port_data == port_addr) || (BCAST_EN && (port_data == '1));
  // Free space is taken from registered occupancy, i.e. before any same-cycle pop.
  assign w_free  = c_depth - fill_q;
  assign w_fits  = CW'(w_free) >= (CW'(port_data) + CW'(1));
  assign w_pop   = port_rd && (fill_q != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_push     = 1'b0;
    w_drop_inc = 1'b0;
    w_err_inc  = 1'b0;
    case (state_q)
      c_st_idle: begin
        if (w_start) state_d = w_match ? c_st_len : c_st_skip;
      end
      c_st_len: begin
        if (!sw_en) begin
          w_err_inc = 1'b1;
          state_d   = c_st_idle;
        end else if (w_fits) begin
          w_push  = 1'b1;
          cnt_d   = port_data;
          state_d = (port_data == '0) ? c_st_waitend : c_st_payload;
        end else begin
          w_drop_inc = 1'b1;
          state_d    = c_st_skip;
        end
      end
      c_st_payload: begin
        if (sw_en) begin
          w_push = 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == W_WIDTH'(1)) state_d = c_st_waitend;
        end else begin
          // Words already queued stay; the truncation is only counted.
          w_err_inc = 1'b1;
          state_d   = c_st_idle;
        end
      end
      c_st_waitend, c_st_skip: begin
        if (!sw_en) state_d = c_st_idle;
      end
      default: state_d = c_st_idle;
    endcase
  end

  assign drop_d = (w_drop_inc && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
  assign err_d  = (w_err_inc  && (err_q  != '1)) ? err_q  + 1'b1 : err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_st_idle;
      cnt_q      <= '0;
      sw_en_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      port_out_q <= '0;
      drop_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_en_q <= sw_en;
      drop_q  <= drop_d;
      err_q   <= err_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop) begin
        port_out_q <= mem_q[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= port_data;
  end

  assign rd_out     = (fill_q != c_depth);
  assign port_rdy   = (fill_q != '0);
  assign port_out   = port_out_q;
  assign fill_level = fill_q;
  assign drop_cnt   = drop_q;
  assign err_cnt    = err_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (fill_q == c_depth)));

endmodule
`default_nettype wire
